// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared state encoding, counter widths and default expected values for the sysid checker
package sysid_check_pkg;
    localparam int TMO_W   = 8;
    localparam int RETRY_W = 2;
    localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'd1575711232;
    typedef logic [2:0] state_t;
    localparam state_t S_START   = 3'd0;
    localparam state_t S_RD_ID   = 3'd1;
    localparam state_t S_WAIT_ID = 3'd2;
    localparam state_t S_RD_TS   = 3'd3;
    localparam state_t S_WAIT_TS = 3'd4;
    localparam state_t S_COMPARE = 3'd5;
    localparam state_t S_DONE    = 3'd6;
endpackage

// File: rtl/avm_single_read.sv
// avm_single_read: one Avalon-MM read with waitrequest, optional readdatavalid and a cycle timeout
//   clk_i/rst_ni         clock, async active-low reset
//   start_i              clears the timeout counter (next cycle starts a fresh attempt)
//   req_i / wait_i       caller is in its request / waiting-for-data phase
//   avm_*                Avalon-MM master side (read, waitrequest, readdatavalid, readdata)
//   accept_o             request accepted this cycle
//   valid_o / data_o     read data available this cycle
//   timeout_o            attempt expired; the caller must abort
module avm_single_read import sysid_check_pkg::*; #(
    parameter int USE_READDATAVALID = 0,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        req_i,
    input  logic        wait_i,
    input  logic        avm_waitrequest_i,
    input  logic        avm_readdatavalid_i,
    input  logic [31:0] avm_readdata_i,
    output logic        avm_read_o,
    output logic        accept_o,
    output logic        valid_o,
    output logic        timeout_o,
    output logic [31:0] data_o
);
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             expired;
    // Once expired the request is withdrawn for one dead cycle, so a retry shows a clean read edge.
    assign expired    = int'(cnt_q) >= TIMEOUT_CYCLES;
    assign avm_read_o = req_i & ~expired;
    assign accept_o   = avm_read_o & ~avm_waitrequest_i;
    assign valid_o    = (USE_READDATAVALID != 0) ? (wait_i & ~expired & avm_readdatavalid_i) : accept_o;
    assign timeout_o  = (req_i | wait_i) & expired;
    assign data_o     = avm_readdata_i;
    assign cnt_d      = start_i ? '0 : ((req_i | wait_i) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sysid_check_sequencer.sv
// sysid_check_sequencer: boot-time reader/checker of the sysid peripheral (word 0 = ID, word 1 = timestamp)
//   clock/reset_n                  clock, async active-low reset
//   recheck                        pulse in DONE restarts the sequence
//   avm_address/avm_read           Avalon-MM request to the sysid slave
//   avm_readdata/avm_waitrequest/avm_readdatavalid   slave response
//   id_value/timestamp_value       captured words
//   busy/done/id_ok/ts_ok/pass     sequence status
//   timeout_err/retry_count        retry bookkeeping
module sysid_check_sequencer import sysid_check_pkg::*; #(
    parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TS,
    parameter int          CHECK_TIMESTAMP    = 1,
    parameter int          USE_READDATAVALID  = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               recheck,
    output logic               avm_address,
    output logic               avm_read,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_waitrequest,
    input  logic               avm_readdatavalid,
    output logic [31:0]        id_value,
    output logic [31:0]        timestamp_value,
    output logic               busy,
    output logic               done,
    output logic               id_ok,
    output logic               ts_ok,
    output logic               pass,
    output logic               timeout_err,
    output logic [RETRY_W-1:0] retry_count
);
    state_t             state_q, state_d;
    logic [31:0]        id_q, id_d, ts_q, ts_d, rd_data;
    logic               id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, terr_q, terr_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               in_rd, in_wait, is_ts, rd_start, rd_accept, rd_valid, rd_timeout;

    assign in_rd   = state_q == S_RD_ID || state_q == S_RD_TS;
    assign in_wait = state_q == S_WAIT_ID || state_q == S_WAIT_TS;
    assign is_ts   = state_q == S_RD_TS || state_q == S_WAIT_TS;
    // Counter restarts on every entry into a read state, including a retry back into RD_ID.
    assign rd_start = (state_d == S_RD_ID || state_d == S_RD_TS) && (state_d != state_q || rd_timeout);

    avm_single_read #(
        .USE_READDATAVALID (USE_READDATAVALID),
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
    ) u_rd (
        .clk_i               (clock),
        .rst_ni              (reset_n),
        .start_i             (rd_start),
        .req_i               (in_rd),
        .wait_i              (in_wait),
        .avm_waitrequest_i   (avm_waitrequest),
        .avm_readdatavalid_i (avm_readdatavalid),
        .avm_readdata_i      (avm_readdata),
        .avm_read_o          (avm_read),
        .accept_o            (rd_accept),
        .valid_o             (rd_valid),
        .timeout_o           (rd_timeout),
        .data_o              (rd_data)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ts_d    = ts_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        terr_d  = terr_q;
        retry_d = retry_q;
        case (state_q)
            S_START: state_d = S_RD_ID;
            S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS: begin
                if (rd_valid) begin
                    id_d    = is_ts ? id_q : rd_data;
                    ts_d    = is_ts ? rd_data : ts_q;
                    state_d = is_ts ? S_COMPARE : S_RD_TS;
                end else if (rd_accept && USE_READDATAVALID != 0) begin
                    state_d = is_ts ? S_WAIT_TS : S_WAIT_ID;
                end else if (rd_timeout) begin
                    if (int'(retry_q) < MAX_RETRIES) begin
                        retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                        state_d = S_RD_ID;
                    end else begin
                        terr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_COMPARE: begin
                id_ok_d = id_q == EXPECTED_ID;
                ts_ok_d = (CHECK_TIMESTAMP == 0) || (ts_q == EXPECTED_TIMESTAMP);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (recheck) begin
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    terr_d  = 1'b0;
                    retry_d = '0;
                    state_d = S_RD_ID;
                end
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_START;
            id_q    <= '0;
            ts_q    <= '0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            terr_q  <= 1'b0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            terr_q  <= terr_d;
            retry_q <= retry_d;
        end
    end

    // All status outputs decode registers only, so done and pass move together on one edge.
    assign avm_address     = is_ts;
    assign busy            = in_rd | in_wait | (state_q == S_COMPARE);
    assign done            = state_q == S_DONE;
    assign pass            = done & id_ok_q & ts_ok_q & ~terr_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout_err     = terr_q;
    assign retry_count     = retry_q;
    assign id_value        = id_q;
    assign timestamp_value = ts_q;
endmodule

// File: tb/tb_sysid_check_sequencer.sv
// tb_sysid_check_sequencer: scoreboard bench over three configurations (default, no-timestamp-check, readdatavalid)
module tb_sysid_check_sequencer;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1575711232;

    typedef struct {
        int          g;
        logic [31:0] id;
        logic [31:0] ts;
        logic        id_ok;
        logic        ts_ok;
        logic        pass;
        logic        terr;
        logic [1:0]  retry;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  recheck, stray, addr, rd, wr, rdv, busy, done, id_ok, ts_ok, pass, terr;
    logic [2:0]  rd_q = '0, wr_q = '0, addr_q = '0;
    logic [31:0] rdata [3];
    logic [31:0] idv [3];
    logic [31:0] tsv [3];
    logic [1:0]  rc [3];
    logic [31:0] pdata [3];
    int          wcnt [3] = '{0, 0, 0};
    int          pcnt [3] = '{0, 0, 0};
    int          rises [3] = '{0, 0, 0};
    int          addr_bad = 0;
    logic [31:0] id_word, ts_word;
    int          wr_len;
    logic [31:0] last_id [3];
    logic [31:0] last_ts [3];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        sysid_check_sequencer #(
            .EXPECTED_ID        (EXP_ID),
            .EXPECTED_TIMESTAMP (EXP_TS),
            .CHECK_TIMESTAMP    (g == 1 ? 0 : 1),
            .USE_READDATAVALID  (g == 2 ? 1 : 0),
            .TIMEOUT_CYCLES     (8),
            .MAX_RETRIES        (3)
        ) u_dut (
            .clock             (clk),
            .reset_n           (reset_n),
            .recheck           (recheck[g]),
            .avm_address       (addr[g]),
            .avm_read          (rd[g]),
            .avm_readdata      (rdata[g]),
            .avm_waitrequest   (wr[g]),
            .avm_readdatavalid (rdv[g]),
            .id_value          (idv[g]),
            .timestamp_value   (tsv[g]),
            .busy              (busy[g]),
            .done              (done[g]),
            .id_ok             (id_ok[g]),
            .ts_ok             (ts_ok[g]),
            .pass              (pass[g]),
            .timeout_err       (terr[g]),
            .retry_count       (rc[g])
        );
    end

    // Slave model: waitrequest for wr_len cycles per read; instance 2 returns data 3 cycles after accept.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wr[i]    = rd[i] && (wcnt[i] < wr_len);
            rdv[i]   = (pcnt[i] == 1) || stray[i];
            rdata[i] = (i == 2) ? ((pcnt[i] == 1) ? pdata[i] : 32'hBAD0_BAD0) : (addr[i] ? ts_word : id_word);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            wcnt[i] <= (rd[i] && wr[i]) ? wcnt[i] + 1 : 0;
            if (i == 2 && rd[i] && !wr[i]) begin
                pcnt[i]  <= 3;
                pdata[i] <= addr[i] ? ts_word : id_word;
            end else if (pcnt[i] != 0) begin
                pcnt[i] <= pcnt[i] - 1;
            end
            if (rd[i] && !rd_q[i]) rises[i] <= rises[i] + 1;
            if (rd_q[i] && wr_q[i] && rd[i] && addr[i] != addr_q[i]) addr_bad <= addr_bad + 1;
            rd_q[i]   <= rd[i];
            wr_q[i]   <= wr[i];
            addr_q[i] <= addr[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic push_exp(input int g, input bit stuck);
        exp_t e;
        e.g = g;
        if (stuck) begin
            e.id = last_id[g]; e.ts = last_ts[g];
            e.id_ok = 1'b0; e.ts_ok = 1'b0; e.pass = 1'b0; e.terr = 1'b1; e.retry = 2'd3;
        end else begin
            e.id = id_word; e.ts = ts_word;
            e.id_ok = id_word == EXP_ID;
            e.ts_ok = (g == 1) || (ts_word == EXP_TS);
            e.pass = e.id_ok && e.ts_ok; e.terr = 1'b0; e.retry = 2'd0;
            last_id[g] = id_word; last_ts[g] = ts_word;
        end
        sb.push_back(e);
    endtask

    task automatic pulse_recheck(input int g);
        @(negedge clk) recheck[g] = 1'b1;
        @(negedge clk) recheck[g] = 1'b0;
    endtask

    task automatic start_seq(input int g, input bit stuck);
        push_exp(g, stuck);
        pulse_recheck(g);
    endtask

    task automatic check_seq();
        exp_t e;
        e = sb.pop_front();
        for (int n = 0; n < 200 && !done[e.g]; n++) @(negedge clk);
        check($sformatf("g%0d_done", e.g), 32'(done[e.g]), 32'd1);
        check($sformatf("g%0d_busy", e.g), 32'(busy[e.g]), 32'd0);
        check($sformatf("g%0d_id", e.g), idv[e.g], e.id);
        check($sformatf("g%0d_ts", e.g), tsv[e.g], e.ts);
        check($sformatf("g%0d_id_ok", e.g), 32'(id_ok[e.g]), 32'(e.id_ok));
        check($sformatf("g%0d_ts_ok", e.g), 32'(ts_ok[e.g]), 32'(e.ts_ok));
        check($sformatf("g%0d_pass", e.g), 32'(pass[e.g]), 32'(e.pass));
        check($sformatf("g%0d_terr", e.g), 32'(terr[e.g]), 32'(e.terr));
        check($sformatf("g%0d_retry", e.g), 32'(rc[e.g]), 32'(e.retry));
    endtask

    initial begin
        int r0, ab0;
        recheck = '0; stray = '0; id_word = EXP_ID; ts_word = EXP_TS; wr_len = 0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read_addr", {26'd0, rd, addr}, 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_ts", tsv[0], 32'd0);
        for (int i = 0; i < 3; i++) push_exp(i, 1'b0);
        reset_n = 1'b1;
        @(negedge clk) check("lat_e1", {30'd0, rd[0], addr[0]}, 32'd2);
        @(negedge clk) check("lat_e2", {30'd0, rd[0], addr[0]}, 32'd3);
        @(negedge clk) check("lat_e3", {29'd0, rd[0], done[0], busy[0]}, 32'd1);
        @(negedge clk) check("lat_e4", {30'd0, done[0], pass[0]}, 32'd3);
        repeat (3) check_seq();
        wr_len = 5; ab0 = addr_bad;
        start_seq(0, 1'b0);
        check_seq();
        check("addr_stable", 32'(addr_bad - ab0), 32'd0);
        wr_len = 0; ts_word = 32'h5DEB_0001;
        start_seq(0, 1'b0);
        check_seq();
        start_seq(1, 1'b0);
        check_seq();
        wr_len = 100000; r0 = rises[0];
        start_seq(0, 1'b1);
        check_seq();
        check("to_attempts", 32'(rises[0] - r0), 32'd4);
        wr_len = 2; ts_word = EXP_TS;
        start_seq(2, 1'b0);
        check_seq();
        @(negedge clk) stray[2] = 1'b1;
        @(negedge clk) stray[2] = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_ts", tsv[2], EXP_TS);
        check("stray_id", idv[2], EXP_ID);
        check("stray_done", 32'(done[2]), 32'd1);
        start_seq(2, 1'b0);
        check("rechk_busy_done", {30'd0, busy[2], done[2]}, 32'd2);
        check_seq();
        pulse_recheck(2);
        for (int n = 0; n < 100 && !(addr[2] && !rd[2] && busy[2]); n++) @(negedge clk);
        check("reach_wait_ts", {29'd0, addr[2], rd[2], busy[2]}, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check("arst_ctrl", {28'd0, busy[2], done[2], addr[2], rd[2]}, 32'd0);
        check("arst_status", {27'd0, pass[2], id_ok[2], ts_ok[2], rc[2]}, 32'd0);
        check("arst_ts", tsv[2], 32'd0);
        for (int i = 0; i < 3; i++) push_exp(i, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) check_seq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
